// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address + R/W, ACK check, one data byte, STOP.
// Define CLK_STRETCH_EN to let a slave stretch SCL during the high quarters of a bit.
module i2c_master_ctrl #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic [3:0] dbg_state,
   inout  wire        SDA,
   inout  wire        SCL
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_START    = 4'd1;
   localparam logic [3:0] S_ADDR     = 4'd2;
   localparam logic [3:0] S_ADDR_ACK = 4'd3;
   localparam logic [3:0] S_WDATA    = 4'd4;
   localparam logic [3:0] S_WACK     = 4'd5;
   localparam logic [3:0] S_RDATA    = 4'd6;
   localparam logic [3:0] S_MNACK    = 4'd7;
   localparam logic [3:0] S_STOP     = 4'd8;
   localparam logic [3:0] S_DONE     = 4'd9;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [3:0] state_q, state_d;
   logic [7:0] div_q, div_d;
   logic [1:0] qtr_q, qtr_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] wdata_q, wdata_d;
   logic       rw_q, rw_d;
   logic       ack_samp_q, ack_samp_d;
   logic       ack_err_q, ack_err_d;
   logic [7:0] rdata_q, rdata_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       sda_oe_q, sda_oe_d;
   logic       scl_oe_q, scl_oe_d;

   logic active, stall, tick, bit_end, sample, sda_in;

   // Bus lines are treated as synchronous to clk; the host environment provides any synchronisers.
   assign sda_in = SDA;
   assign active = (state_q != S_IDLE) && (state_q != S_DONE);

`ifdef CLK_STRETCH_EN
   assign stall = active && qtr_q[1] && !scl_oe_q && (SCL == 1'b0);
`else
   logic scl_unused;
   assign scl_unused = SCL;
   assign stall = 1'b0;
`endif

   assign tick    = active && !stall && (div_q == DIV_LAST);
   assign bit_end = tick && (qtr_q == 2'd3);
   assign sample  = active && !stall && (qtr_q == 2'd3) && (div_q == 8'd0);

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      qtr_d      = qtr_q;
      bit_d      = bit_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      wdata_d    = wdata_q;
      rw_d       = rw_q;
      ack_samp_d = ack_samp_q;
      ack_err_d  = ack_err_q;
      rdata_d    = rdata_q;

      if (active && !stall) begin
         if (tick) begin
            div_d = 8'd0;
            qtr_d = qtr_q + 2'd1;
         end else begin
            div_d = div_q + 8'd1;
         end
      end

      if (sample) begin
         ack_samp_d = sda_in;
         if (state_q == S_RDATA) rx_d = {rx_q[6:0], sda_in};
      end

      case (state_q)
         S_IDLE: begin
            div_d = 8'd0;
            qtr_d = 2'd0;
            bit_d = 3'd0;
            if (start) begin
               state_d   = S_START;
               tx_d      = {addr, rw};
               rw_d      = rw;
               wdata_d   = wdata;
               ack_err_d = 1'b0;
            end
         end
         S_START: if (bit_end) state_d = S_ADDR;
         S_ADDR: if (bit_end) begin
            tx_d  = {tx_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_ADDR_ACK;
         end
         S_ADDR_ACK: if (bit_end) begin
            if (ack_samp_q) begin
               ack_err_d = 1'b1;
               state_d   = S_STOP;
            end else if (rw_q) begin
               state_d = S_RDATA;
            end else begin
               state_d = S_WDATA;
               tx_d    = wdata_q;
            end
         end
         S_WDATA: if (bit_end) begin
            tx_d  = {tx_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_WACK;
         end
         S_WACK: if (bit_end) begin
            ack_err_d = ack_err_q | ack_samp_q;
            state_d   = S_STOP;
         end
         S_RDATA: if (bit_end) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_MNACK;
         end
         S_MNACK: if (bit_end) state_d = S_STOP;
         S_STOP: if (bit_end) begin
            state_d = S_DONE;
            if (rw_q && !ack_err_q) rdata_d = rx_q;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Line drivers and status flags are decoded from next-state values so they leave flops glitch-free.
      busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d   = (state_d == S_DONE);
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      case (state_d)
         S_START: sda_oe_d = qtr_d[1];
         S_ADDR, S_WDATA: begin
            scl_oe_d = !qtr_d[1];
            sda_oe_d = !tx_d[7];
         end
         S_ADDR_ACK, S_WACK, S_RDATA, S_MNACK: scl_oe_d = !qtr_d[1];
         S_STOP: begin
            scl_oe_d = !qtr_d[1];
            sda_oe_d = (qtr_d != 2'd3);
         end
         default: begin
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         div_q      <= 8'd0;
         qtr_q      <= 2'd0;
         bit_q      <= 3'd0;
         tx_q       <= 8'd0;
         rx_q       <= 8'd0;
         wdata_q    <= 8'd0;
         rw_q       <= 1'b0;
         ack_samp_q <= 1'b0;
         ack_err_q  <= 1'b0;
         rdata_q    <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         scl_oe_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         qtr_q      <= qtr_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         wdata_q    <= wdata_d;
         rw_q       <= rw_d;
         ack_samp_q <= ack_samp_d;
         ack_err_q  <= ack_err_d;
         rdata_q    <= rdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         sda_oe_q   <= sda_oe_d;
         scl_oe_q   <= scl_oe_d;
      end
   end

   assign SDA       = sda_oe_q ? 1'b0 : 1'bz;
   assign SCL       = scl_oe_q ? 1'b0 : 1'bz;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign ack_err   = ack_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a bus-level slave/monitor, a vector table of single-byte
// transactions, and hand sequences for busy-start, DONE-cycle start, clock stretch and reset.
module tb_i2c_master_ctrl;

   localparam int D     = 4;
   localparam int W_CYC = 80 * D + 1;
   localparam int N_CYC = 44 * D + 1;
   localparam int LIMIT = 80 * D + 50;
   localparam int NV    = 9;
   localparam logic [6:0] SLV_ADDR = 7'h78;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       rw;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic [3:0] dbg_state;

   wire sda_bus;
   wire scl_bus;
   pullup (sda_bus);
   pullup (scl_bus);

   logic slv_sda_low = 1'b0;
   logic tb_scl_low  = 1'b0;
   assign sda_bus = slv_sda_low ? 1'b0 : 1'bz;
   assign scl_bus = tb_scl_low ? 1'b0 : 1'bz;

   i2c_master_ctrl #(.CLK_DIV(D)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err), .dbg_state(dbg_state),
      .SDA(sda_bus), .SCL(scl_bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- slave model / bus monitor ----------------
   logic [7:0] slv_rdata    = 8'h00;
   logic       slv_ack_data = 1'b1;
   logic       slv_acked    = 1'b0;
   logic       slv_is_read  = 1'b0;
   logic       sda_p = 1'b1;
   logic       scl_p = 1'b1;
   int         mon_k = 0;
   int         mon_stops = 0;
   logic [7:0] mon_addr = 8'h00;
   logic [7:0] mon_data = 8'h00;
   logic       mon_b9 = 1'b1;
   logic       mon_b18 = 1'b1;

   always @(negedge clk) begin
      if (scl_p && scl_bus && sda_p && !sda_bus) begin
         mon_k = 0; mon_addr = 8'h00; mon_data = 8'h00; slv_acked = 1'b0;
      end else if (scl_p && scl_bus && !sda_p && sda_bus) begin
         mon_stops++;
      end else if (!scl_p && scl_bus) begin
         mon_k++;
         if (mon_k <= 8)       mon_addr = {mon_addr[6:0], sda_bus};
         else if (mon_k == 9)  mon_b9 = sda_bus;
         else if (mon_k <= 17) mon_data = {mon_data[6:0], sda_bus};
         else if (mon_k == 18) mon_b18 = sda_bus;
      end else if (scl_p && !scl_bus) begin
         slv_sda_low = 1'b0;
         if (mon_k == 8) begin
            slv_acked   = (mon_addr[7:1] == SLV_ADDR);
            slv_is_read = mon_addr[0];
            slv_sda_low = slv_acked;
         end else if (slv_acked && slv_is_read && mon_k >= 9 && mon_k <= 16) begin
            slv_sda_low = !slv_rdata[16 - mon_k];
         end else if (slv_acked && !slv_is_read && mon_k == 17) begin
            slv_sda_low = slv_ack_data;
         end
      end
      sda_p = sda_bus;
      scl_p = scl_bus;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic start_txn(input logic r, input logic [6:0] a, input logic [7:0] w);
      @(negedge clk);
      rw = r; addr = a; wdata = w; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("busy_on_accept", busy, 1);
      check("ack_err_cleared", ack_err, 0);
   endtask

   // Returns the cycle number (first cycle after the accepting edge = 1) at which done is seen.
   task automatic wait_done(input int stretch_at, output int cyc);
      logic got;
      got = 1'b0;
      cyc = 1;
      while (cyc < LIMIT) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (stretch_at != 0 && cyc == stretch_at - 1) tb_scl_low = 1'b1;
         if (stretch_at != 0 && cyc == stretch_at + 10) tb_scl_low = 1'b0;
         @(negedge clk);
         cyc++;
      end
      tb_scl_low = 1'b0;
      check("done_seen", got, 1);
   endtask

   typedef struct {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
      logic [7:0] srd;
      logic       sack;
      int         exp_cyc;
      logic       exp_err;
      logic [7:0] exp_rdata;
      logic [7:0] exp_abyte;
      logic [7:0] exp_dbyte;
      logic       exp_b9;
      logic       exp_b18;
      int         exp_rises;
   } vec_t;

   vec_t vecs[NV];

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int stops0;
      int dones;
      int done_cyc;

      vecs[0] = '{1'b0, 7'h78, 8'hB3, 8'h00, 1'b1, W_CYC, 1'b0, 8'h00, 8'hF0, 8'hB3, 1'b0, 1'b0, 19};
      vecs[1] = '{1'b1, 7'h78, 8'h00, 8'hA5, 1'b1, W_CYC, 1'b0, 8'hA5, 8'hF1, 8'hA5, 1'b0, 1'b1, 19};
      vecs[2] = '{1'b0, 7'h22, 8'h11, 8'h00, 1'b1, N_CYC, 1'b1, 8'hA5, 8'h44, 8'h00, 1'b1, 1'b0, 10};
      vecs[3] = '{1'b1, 7'h22, 8'h00, 8'h00, 1'b1, N_CYC, 1'b1, 8'hA5, 8'h45, 8'h00, 1'b1, 1'b0, 10};
      vecs[4] = '{1'b0, 7'h78, 8'h5C, 8'h00, 1'b0, W_CYC, 1'b1, 8'hA5, 8'hF0, 8'h5C, 1'b0, 1'b1, 19};
      vecs[5] = '{1'b1, 7'h78, 8'h00, 8'h3C, 1'b1, W_CYC, 1'b0, 8'h3C, 8'hF1, 8'h3C, 1'b0, 1'b1, 19};
      vecs[6] = '{1'b0, 7'h78, 8'h00, 8'h00, 1'b1, W_CYC, 1'b0, 8'h3C, 8'hF0, 8'h00, 1'b0, 1'b0, 19};
      vecs[7] = '{1'b0, 7'h78, 8'hFF, 8'h00, 1'b1, W_CYC, 1'b0, 8'h3C, 8'hF0, 8'hFF, 1'b0, 1'b0, 19};
      vecs[8] = '{1'b1, 7'h78, 8'h00, 8'h00, 1'b1, W_CYC, 1'b0, 8'h00, 8'hF1, 8'h00, 1'b0, 1'b1, 19};

      reset_n = 1'b0; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_sda", sda_bus, 1);
      check("reset_scl", scl_bus, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_ack_err", ack_err, 0);
      check("reset_rdata", rdata, 8'h00);
      check("reset_state", dbg_state, 0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         slv_rdata = vecs[i].srd;
         slv_ack_data = vecs[i].sack;
         stops0 = mon_stops;
         start_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
         wait_done(0, cyc);
         check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
         check($sformatf("v%0d_busy_at_done", i), busy, 0);
         check($sformatf("v%0d_ack_err", i), ack_err, vecs[i].exp_err);
         check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
         check($sformatf("v%0d_addr_byte", i), mon_addr, vecs[i].exp_abyte);
         check($sformatf("v%0d_addr_ack_bit", i), mon_b9, vecs[i].exp_b9);
         check($sformatf("v%0d_scl_rises", i), mon_k, vecs[i].exp_rises);
         check($sformatf("v%0d_stop_seen", i), mon_stops, stops0 + 1);
         if (vecs[i].exp_rises == 19) begin
            check($sformatf("v%0d_data_byte", i), mon_data, vecs[i].exp_dbyte);
            check($sformatf("v%0d_ninth_data_bit", i), mon_b18, vecs[i].exp_b18);
         end
         @(negedge clk);
         check($sformatf("v%0d_done_pulse_end", i), done, 0);
         check($sformatf("v%0d_idle_after", i), dbg_state, 0);
      end

      // start pulsed mid-ADDR with a different address must be ignored
      slv_ack_data = 1'b1;
      start_txn(1'b0, 7'h78, 8'hB3);
      cyc = 1; dones = 0; done_cyc = 0;
      while (cyc < LIMIT) begin
         if (done) begin
            dones++;
            if (done_cyc == 0) done_cyc = cyc;
         end
         if (cyc == 20) begin
            start = 1'b1; addr = 7'h22; rw = 1'b1; wdata = 8'h00;
         end
         if (cyc == 21) start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      check("busy_start_done_count", dones, 1);
      check("busy_start_done_cycle", done_cyc, W_CYC);
      check("busy_start_addr_byte", mon_addr, 8'hF0);
      check("busy_start_data_byte", mon_data, 8'hB3);

      // start held from the DONE cycle is accepted only from IDLE
      start_txn(1'b0, 7'h78, 8'h3C);
      wait_done(0, cyc);
      rw = 1'b0; addr = 7'h78; wdata = 8'h96; start = 1'b1;
      @(negedge clk);
      check("done_cycle_start_ignored", busy, 0);
      @(negedge clk);
      start = 1'b0;
      check("idle_start_accepted", busy, 1);
      wait_done(0, cyc);
      check("late_start_cycles", cyc, W_CYC);
      check("late_start_data_byte", mon_data, 8'h96);
      @(negedge clk);

`ifdef CLK_STRETCH_EN
      // slave stretches SCL for 10 cycles from Q2 of the third data bit
      slv_rdata = 8'hC3;
      start_txn(1'b1, 7'h78, 8'h00);
      wait_done(50 * D + 1, cyc);
      check("stretch_cycles", cyc, W_CYC + 10);
      check("stretch_rdata", rdata, 8'hC3);
      check("stretch_ack_err", ack_err, 0);
      @(negedge clk);
`endif

      // asynchronous reset in the middle of the data byte
      start_txn(1'b0, 7'h78, 8'hC4);
      cyc = 1;
      while (cyc < 45 * D + 1) begin
         @(negedge clk);
         cyc++;
      end
      check("pre_reset_state_wdata", dbg_state, 4);
      stops0 = mon_stops;
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_sda", sda_bus, 1);
      check("async_reset_scl", scl_bus, 1);
      check("async_reset_busy", busy, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      check("post_reset_rdata", rdata, 8'h00);
      check("post_reset_no_stop", mon_stops, stops0);
      stops0 = mon_stops;
      start_txn(1'b0, 7'h78, 8'h6A);
      wait_done(0, cyc);
      check("fresh_write_cycles", cyc, W_CYC);
      check("fresh_write_ack_err", ack_err, 0);
      check("fresh_write_data_byte", mon_data, 8'h6A);
      check("fresh_write_stop", mon_stops, stops0 + 1);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Single-byte I2C master controller that sequences bus transactions toward i2c_slave on the shared open-drain SDA/SCL pair.
- Accepts a command (7-bit address, R/W, write byte) from a local host.
- Generates START, address phase, ACK check, one data byte (write or read), master NACK on read, then STOP.
- Returns read data and an ACK-error flag.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV clk cycles); legal range 2..255.

Ports:
clk  input  1  system clock, single clock domain
reset_n  input  1  asynchronous active-low reset
start  input  1  command request; sampled on rising clk edge while busy=0
rw  input  1  0 = write, 1 = read; captured with start
addr  input  7  target slave address, captured with start
wdata  input  8  write byte, captured with start
rdata  output  8  read byte, MSB received first
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
ack_err  output  1  high if the slave NACKed the address or the write data
SDA  inout  1  open-drain: driven 0 or z, external pullup
SCL  inout  1  open-drain: driven 0 or z, external pullup

Behaviour:
- Reset (async, immediate): SDA=z, SCL=z, busy=0, done=0, ack_err=0, rdata=8'h00, state=IDLE, quarter/bit counters=0. Reset mid-transaction aborts with no STOP generated.
- Bit timing: each bit-time has quarters Q0..Q3, each CLK_DIV cycles.
  - Q0–Q1: SCL driven low. SDA changes at the first cycle of Q0.
  - Q2–Q3: SCL released.
  - Receive sampling of SDA happens at the first cycle of Q3.
- States: IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, MNACK, STOP, DONE.
- IDLE: lines released. start=1 latches {addr,rw,wdata}, clears ack_err, sets busy, then enters START.
- START (1 bit-time):
  - Q0–Q1: SDA=z, SCL=z.
  - Q2–Q3: SDA=0, SCL=z, which forms the START condition.
- ADDR (8 bit-times): shifts {addr[6:0],rw} MSB first.
- ADDR_ACK (1 bit-time): SDA released; sample SDA.
  - 0 → WDATA if rw=0, RDATA if rw=1.
  - 1 → ack_err=1, go to STOP (data phase skipped).
- WDATA (8 bit-times): shifts wdata MSB first.
- WACK (1 bit-time): SDA released; sample SDA. A 1 sets ack_err. Always go to STOP.
- RDATA (8 bit-times): SDA released; shift sampled bit into a shift register, MSB first.
- MNACK (1 bit-time): SDA released (master NACK ends the read).
- STOP (1 bit-time):
  - Q0–Q1: SCL=0, SDA=0.
  - Q2: SCL=z, SDA=0.
  - Q3: SCL=z, SDA=z.
- DONE (1 cycle): done=1, busy=0. Then IDLE.
- rdata updates in DONE only for a read with no ack_err; otherwise it holds its previous value.
- Latency: with start accepted at edge 0, done pulses at cycle 1 + 4*CLK_DIV*N.
  - N=20 for a completed write or read.
  - N=11 for an address NACK.
- start while busy=1 is ignored; no queueing.
- ack_err holds its value until the next accepted start.
- start asserted in the DONE cycle is ignored; it is accepted in IDLE on the following cycle.

Optional Feature:
CLK_STRETCH_EN
- Defined: during Q2 and Q3 of any bit-time, if SCL is read as 0 while released, the quarter counter freezes until SCL reads 1. This supports slave clock stretching. Latency grows by the stretch duration.
- Undefined: the SCL input is ignored and timing is fixed as above.

Test Plan:
- Write, addr=7'h78, wdata=8'hB3, slave ACKs:
  - Address byte on SDA is 1111000_0 and the data byte is 10110011.
  - done at cycle 80*CLK_DIV+1, ack_err=0, STOP seen (SDA rises while SCL high).
- Read, addr=7'h78, slave model drives 8'hA5:
  - rdata=8'hA5 at done.
  - Master leaves SDA released on the 9th data clock (NACK), then STOP.
- Address NACK (no slave pulls SDA):
  - ack_err=1, no data clocks, STOP follows ADDR_ACK.
  - done at cycle 44*CLK_DIV+1; rdata unchanged.
- start pulsed mid-ADDR with different addr:
  - Ignored; the original address completes; exactly one done pulse.
- reset_n low mid-WDATA:
  - SDA=z, SCL=z, busy=0 immediately without waiting for clk.
  - A fresh write after release completes normally.
- With CLK_STRETCH_EN, slave holds SCL low 10 cycles after the 3rd data bit's Q2:
  - Bit counter stalls; done delayed by exactly 10 cycles.
  - Data still received correctly.
